// File: rtl/psc_pkg.sv
// Shared definitions for the PSC trigger scheduler: FSM states, link frame
// geometry and default holdoff/timeout frame counts.
package psc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    HOLDOFF = 2'd2
  } psc_state_e;

  localparam int PSC_FRAME_BITS     = 100;
  localparam int GAP_FRAMES_DEF     = 1;
  localparam int TIMEOUT_FRAMES_DEF = 4;

  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/psc_rr_arbiter.sv
// Combinational round-robin pick: the first requesting source after
// last_grant (wrapping) wins.
module psc_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [SRC_W-1:0]   grant_idx
);

  // Walk the ring from farthest to nearest so the nearest requester is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      int s;
      s = (int'(last_grant) + k) % NUM_SRC;
      if (req[s]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(s);
      end
    end
  end

endmodule

// File: rtl/psc_trigger_scheduler.sv
// Latches source event edges and schedules one trigger per frame boundary onto
// the PSC link, with req/ack handshake, ack timeout and post-trigger holdoff.
module psc_trigger_scheduler
  import psc_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int SRC_W          = 2,
  parameter int GAP_FRAMES     = GAP_FRAMES_DEF,
  parameter int TIMEOUT_FRAMES = TIMEOUT_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] evt_in,
  input  logic [NUM_SRC-1:0] src_enable,
  input  logic               frame_tick,
  input  logic               trig_ack,
  output logic               trig_req,
  output logic [SRC_W-1:0]   trig_src,
  output logic               busy,
  output logic               err_timeout,
  output logic [7:0]         drop_cnt,
  input  logic               drop_clr
);

  psc_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] evt_prev, pending, pend_d, rise, req_vec, drop_vec, gnt_hit;
  logic [SRC_W-1:0]   last_grant, lg_d, src_d, gnt_idx;
  logic               gnt_valid, grant_now, req_d, err_d;
  logic [3:0]         tmo_q, tmo_d, gap_q, gap_d;
  logic [8:0]         drop_sum;
  logic [7:0]         drop_d;

  assign rise    = evt_in & ~evt_prev;
  assign req_vec = pending & src_enable;
  assign busy    = (state_q != IDLE);

  psc_rr_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_arb (
    .req         (req_vec),
    .last_grant  (last_grant),
    .grant_valid (gnt_valid),
    .grant_idx   (gnt_idx)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = trig_req;
    src_d     = trig_src;
    err_d     = 1'b0;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    lg_d      = last_grant;
    grant_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick && gnt_valid) begin
          grant_now = 1'b1;
          state_d   = SEND;
          req_d     = 1'b1;
          src_d     = gnt_idx;
          lg_d      = gnt_idx;
          tmo_d     = '0;
        end
      end
      SEND: begin
        // An ack on the terminal tick still counts as a clean completion.
        if (trig_ack) begin
          state_d = HOLDOFF;
          req_d   = 1'b0;
          gap_d   = '0;
        end else if (frame_tick) begin
          tmo_d = tmo_q + 4'd1;
          if (tmo_d == 4'(TIMEOUT_FRAMES)) begin
            err_d   = 1'b1;
            req_d   = 1'b0;
            state_d = HOLDOFF;
            gap_d   = '0;
          end
        end
      end
      HOLDOFF: begin
        if (GAP_FRAMES == 0) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          gap_d = gap_q + 4'd1;
          if (gap_d == 4'(GAP_FRAMES)) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // A rise landing on its own grant cycle re-queues the source instead of dropping.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign gnt_hit[i]  = grant_now && (gnt_idx == SRC_W'(i));
    assign drop_vec[i] = src_enable[i] & rise[i] & pending[i] & ~gnt_hit[i];
    assign pend_d[i]   = !src_enable[i] ? 1'b0 :
                         gnt_hit[i]     ? rise[i] : (pending[i] | rise[i]);
  end

  assign drop_sum = {1'b0, drop_cnt} + {5'b00000, count_ones(8'(drop_vec))};
  assign drop_d   = drop_clr ? 8'h00 : (drop_sum[8] ? 8'hFF : drop_sum[7:0]);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_prev    <= evt_in;
      pending     <= '0;
      last_grant  <= SRC_W'(NUM_SRC - 1);
      trig_req    <= 1'b0;
      trig_src    <= '0;
      err_timeout <= 1'b0;
      tmo_q       <= '0;
      gap_q       <= '0;
      drop_cnt    <= '0;
    end else begin
      evt_prev    <= evt_in;
      pending     <= pend_d;
      last_grant  <= lg_d;
      trig_req    <= req_d;
      trig_src    <= src_d;
      err_timeout <= err_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      drop_cnt    <= drop_d;
    end
  end

endmodule

// File: tb/tb_psc_trigger_scheduler.sv
// Self-checking bench: directed table, corner-case sequences and randomized
// traffic compared against a transaction-level reference model.
module tb_psc_trigger_scheduler;

  localparam int NS  = 4;
  localparam int SW  = 2;
  localparam int GAP = 1;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NS-1:0] evt_in = '0, src_enable = '0;
  logic          frame_tick = 1'b0, trig_ack = 1'b0, drop_clr = 1'b0;
  logic          trig_req, busy, err_timeout;
  logic [SW-1:0] trig_src;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  psc_trigger_scheduler #(.NUM_SRC(NS), .SRC_W(SW), .GAP_FRAMES(GAP), .TIMEOUT_FRAMES(TMO)) dut (
    .clk(clk), .reset(reset), .evt_in(evt_in), .src_enable(src_enable),
    .frame_tick(frame_tick), .trig_ack(trig_ack), .trig_req(trig_req),
    .trig_src(trig_src), .busy(busy), .err_timeout(err_timeout),
    .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 = waiting, 1 = trigger outstanding, 2 = gap.
  bit m_pend[NS];
  bit m_prev[NS];
  int m_last, m_phase, m_ticks, m_src, m_drop;
  bit m_req, m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int g;
    int nd;
    bit r;
    g  = -1;
    nd = 0;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = evt_in[i];
      end
      m_phase = 0; m_req = 0; m_src = 0; m_err = 0; m_drop = 0; m_last = NS - 1; m_ticks = 0;
      return;
    end
    m_err = 0;
    if (m_phase == 0) begin
      if (frame_tick)
        for (int k = 1; k <= NS; k++) begin
          int s;
          s = (m_last + k) % NS;
          if (g < 0 && m_pend[s] && src_enable[s]) g = s;
        end
    end else if (m_phase == 1) begin
      if (trig_ack) begin
        m_phase = 2; m_req = 0; m_ticks = 0;
      end else if (frame_tick) begin
        m_ticks++;
        if (m_ticks == TMO) begin
          m_err = 1; m_req = 0; m_phase = 2; m_ticks = 0;
        end
      end
    end else if (frame_tick) begin
      m_ticks++;
      if (m_ticks == GAP) m_phase = 0;
    end
    for (int i = 0; i < NS; i++) begin
      r = evt_in[i] && !m_prev[i];
      if (!src_enable[i]) m_pend[i] = 0;
      else if (i == g) m_pend[i] = r;
      else begin
        if (r && m_pend[i]) nd++;
        m_pend[i] = m_pend[i] | r;
      end
      m_prev[i] = evt_in[i];
    end
    if (drop_clr) m_drop = 0;
    else m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
    if (g >= 0) begin
      m_phase = 1; m_req = 1; m_src = g; m_last = g; m_ticks = 0;
    end
  endtask

  task automatic step(input logic [NS-1:0] e, input logic [NS-1:0] en,
                      input logic tk, input logic ak, input logic cl, input logic rs);
    evt_in = e; src_enable = en; frame_tick = tk; trig_ack = ak; drop_clr = cl; reset = rs;
    @(posedge clk);
    model_step();
    #1;
    chk("m_req", int'(trig_req), int'(m_req));
    if (m_req) chk("m_src", int'(trig_src), m_src);
    chk("m_busy", int'(busy), int'(m_phase != 0));
    chk("m_err", int'(err_timeout), int'(m_err));
    chk("m_drop", int'(drop_cnt), m_drop);
  endtask

  task automatic serve(input int exp_src, input string name);
    step(evt_in, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk({name, "_req"}, int'(trig_req), 1);
    chk({name, "_src"}, int'(trig_src), exp_src);
    step(evt_in, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    step(evt_in, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [3:0] evt;
    logic       tk, ak, xreq;
    logic [1:0] xsrc;
    logic       xbusy, xerr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[1] = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[2] = '{4'b0100, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[3] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[4] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[5] = '{4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[6] = '{4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[7] = '{4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[8] = '{4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[9] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

    // Reset state
    step(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_req", int'(trig_req), 0);
    chk("rst_src", int'(trig_src), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_timeout), 0);
    chk("rst_drop", int'(drop_cnt), 0);

    // Single event / ack / holdoff table
    for (int k = 0; k < 10; k++) begin
      step(tbl[k].evt, 4'hF, tbl[k].tk, tbl[k].ak, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_req", k), int'(trig_req), int'(tbl[k].xreq));
      if (tbl[k].xreq) chk($sformatf("tbl%0d_src", k), int'(trig_src), int'(tbl[k].xsrc));
      chk($sformatf("tbl%0d_busy", k), int'(busy), int'(tbl[k].xbusy));
      chk($sformatf("tbl%0d_err", k), int'(err_timeout), int'(tbl[k].xerr));
      chk($sformatf("tbl%0d_drop", k), int'(drop_cnt), 0);
    end

    // Round-robin: 0,1,3 pending; 0 re-raised after its grant lands behind 3
    step(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'b1011, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    serve(0, "rr0");
    step(4'b1010, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b1011, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    serve(1, "rr1");
    serve(3, "rr2");
    serve(0, "rr3");

    // Drops and saturation, clear beats increment
    step(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(4'b0010, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
      step(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("drop_two", int'(drop_cnt), 2);
    for (int k = 0; k < 300; k++) begin
      step(4'b0010, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
      step(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("drop_sat", int'(drop_cnt), 255);
    step(4'b0010, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drop_clr", int'(drop_cnt), 0);

    // Timeout, then ack on the terminal tick
    step(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'b0001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_grant", int'(trig_req), 1);
    for (int t = 1; t <= 4; t++) begin
      step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("to_err%0d", t), int'(err_timeout), int'(t == 4));
      chk($sformatf("to_req%0d", t), int'(trig_req), int'(t != 4));
    end
    step(4'b0001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_pulse", int'(err_timeout), 0);
    chk("to_hold", int'(busy), 1);
    step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_noreq", int'(trig_req), 0);
    step(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= 3; t++) step(4'b0001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ackwin_err", int'(err_timeout), 0);
    chk("ackwin_req", int'(trig_req), 0);

    // Masking and rise on own grant cycle
    step(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'b1000, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b1000, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mask_req", int'(trig_req), 0);
    chk("mask_drop", int'(drop_cnt), 0);
    step(4'b0100, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sim_src", int'(trig_src), 2);
    chk("sim_drop", int'(drop_cnt), 0);
    step(4'b0100, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    step(4'b0100, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    serve(2, "sim_requeue");

    // Reset mid-SEND with a level held high
    step(4'b0000, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b1001, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b1001, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rs_send", int'(trig_req), 1);
    step(4'b0010, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rs_req", int'(trig_req), 0);
    chk("rs_busy", int'(busy), 0);
    chk("rs_err", int'(err_timeout), 0);
    chk("rs_drop", int'(drop_cnt), 0);
    for (int t = 0; t < 3; t++) begin
      step(4'b0010, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("rs_nogrant%0d", t), int'(trig_req), 0);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic [NS-1:0] e, en;
      e  = evt_in ^ NS'($urandom_range(0, 15) & $urandom_range(0, 15));
      en = ($urandom_range(0, 9) == 0) ? NS'($urandom_range(0, 15)) : 4'hF;
      step(e, en, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
